mul_seq8: RTL
=============

Name: mul_seq8

Overview:
- Sequencer that computes an 8x8 -> 16-bit product by time-multiplexing one combinational 4x4 array multiplier over four cycles.
- Accepts operands over a valid/ready request port, schedules the four nibble partial products, and accumulates them with shifts into a 16-bit register.
- Returns the product over a valid/ready result port.
- Sits between the ALU/decode logic and the 4x4 multiplier cell, so the 8-bit multiply costs no extra array area.

Parameters:
- SIGNED, 0: 0 = unsigned operands and result; 1 = two's-complement operands and result.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  operands a/b valid
- req_ready  output  1  block can accept operands (high only in IDLE)
- a  input  8  multiplicand
- b  input  8  multiplier
- res_valid  output  1  result valid, held until consumed
- res_ready  input  1  consumer accepts result
- result  output  16  product
- busy  output  1  high in MUL or DONE

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous and active-high, sampled on the rising edge of clk.
  - On reset: state=IDLE, step=0, acc=0, result=0, res_valid=0, busy=0, req_ready=1 from the first cycle after reset.
  - Reset mid-operation aborts the operation; the partial accumulation is discarded.
- States: IDLE, MUL, DONE.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch operand magnitudes ma/mb (SIGNED=1: ma=|a|, mb=|b|, neg=a[7]^b[7]; SIGNED=0: ma=a, mb=b, neg=0). Then clear acc, set step=0, go to MUL.
  - MUL: the multiplier inputs are selected by step, and acc += product<<shift on each edge.
    - step0: ma[3:0]*mb[3:0], shift 0
    - step1: ma[7:4]*mb[3:0], shift 4
    - step2: ma[3:0]*mb[7:4], shift 4
    - step3: ma[7:4]*mb[7:4], shift 8
    - Each add is 16-bit and cannot overflow for unsigned magnitudes (max 0xFE01).
    - After the step3 edge: result=neg ? -acc : acc (16-bit two's complement), res_valid=1, go to DONE.
  - DONE: result and res_valid are held stable. On res_valid&&res_ready, res_valid=0 and go to IDLE. No new request is accepted in the same cycle.
- Latency and throughput:
  - Accept edge E0; the result is valid immediately after edge E4 (4 cycles).
  - Minimum issue interval is 6 cycles: 4 MUL, >=1 DONE, 1 IDLE.
- Boundary rules:
  - a, b are ignored outside the accept handshake. Operand changes during MUL do not affect the result.
  - res_ready in IDLE or MUL has no effect.
  - SIGNED=1: -128*-128 = 0x4000. No saturation.
- Width rules: nibble products are 8-bit zero-extended to 16 before shifting. Negation is 16-bit modular.

Optional Feature:
- Macro: MUL_SEQ8_EARLY_EXIT_EN
- Defined: if ma==0 or mb==0 at accept, skip MUL. The next edge goes straight to DONE with result=0 and res_valid=1 (latency 1 cycle).
- Not defined: every operation takes exactly 4 cycles. Zero operands pass through MUL normally and produce result 0.
- In both cases the state encoding and the port list are identical.

Decomposition:
- Package mul_seq8_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_MUL=2'd1, ST_DONE=2'd2
  - NUM_STEPS=4
  - widths OP_W=8, NIB_W=4, RES_W=16
  - shift table per step: {0,4,4,8}
- Sub-module: instantiate the existing mul2 4x4 combinational multiplier, with inputs driven by the step mux and the 8-bit output feeding the accumulator.
- The FSM, operand mux, accumulator and sign fix-up stay in mul_seq8.

Test Plan:
- Basic unsigned: SIGNED=0, a=0x0F, b=0x0F -> result=0x00E1. res_valid rises exactly 4 cycles after the accept edge; req_ready low from the accept edge until the cycle after the result handshake.
- Max operands: a=0xFF, b=0xFF -> 0xFE01. Also a=0x12, b=0x34 -> 0x03A8.
- Backpressure:
  - Hold res_ready=0 for 3 cycles after res_valid rises. result stays 0xFE01, res_valid stays 1, req_ready stays 0, and a req_valid pulse is ignored.
  - Raising res_ready returns the block to IDLE on the following edge.
- Reset mid-op: start 0xAB*0xCD, assert rst during step2. On the next cycle res_valid=0, result=0, req_ready=1. Then issue 0x12*0x34 -> 0x03A8 with no residue.
- Signed (SIGNED=1): 0x80*0x80 -> 0x4000; 0xFD*0x05 -> 0xFFF1; 0x07*0xF9 -> 0xFFCF; 0x00*0x80 -> 0x0000.
- Early exit: a=0x00, b=0xAB -> 0x0000 with res_valid after 1 cycle when MUL_SEQ8_EARLY_EXIT_EN is defined, and after 4 cycles when it is not. Nonzero operands take 4 cycles in both builds.

Source files
------------

// File: rtl/mul_seq8_pkg.sv
// mul_seq8_pkg: shared types and constants for the sequential 8x8 multiplier.
//   - state_e   : FSM state encoding (IDLE/MUL/DONE)
//   - NUM_STEPS : number of nibble partial products per operation
//   - OP_W/NIB_W/RES_W : operand, nibble and result widths
//   - step_shift: left shift applied to each step's partial product
//   - mag8      : operand magnitude (two's-complement absolute value when signed)
package mul_seq8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_STEPS = 4;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned RES_W     = 16;

  // Shift table {0,4,4,8}: lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      2'd3:    sh = 4'd8;
      default: sh = 4'd0;
    endcase
    return sh;
  endfunction

  // |v| for signed operands; -128 maps to 0x80, which is the correct unsigned magnitude.
  function automatic logic [OP_W-1:0] mag8(input logic [OP_W-1:0] v, input logic is_signed);
    logic [OP_W-1:0] m;
    if (is_signed && v[OP_W-1]) begin
      m = 8'd0 - v;
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/mul_seq8_mul2.sv
// mul2: combinational 4x4 -> 8-bit unsigned array multiplier cell.
//   a_i [3:0] : multiplicand nibble
//   b_i [3:0] : multiplier nibble
//   p_o [7:0] : product
module mul2
  import mul_seq8_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);

  // Plain unsigned product; both operands widened so no bits are lost.
  assign p_o = {4'd0, a_i} * {4'd0, b_i};

endmodule

// File: rtl/mul_seq8.sv
// mul_seq8: 8x8 -> 16-bit multiplier that reuses one 4x4 cell over four cycles.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : operand handshake (ready only in IDLE)
//   a, b                : 8-bit operands, sampled only on the accept edge
//   res_valid/res_ready : result handshake, result held until consumed
//   result              : 16-bit product
//   busy                : high in MUL or DONE
// Parameter SIGNED: 0 = unsigned, 1 = two's complement operands and result.
// Optional build macro MUL_SEQ8_EARLY_EXIT_EN: a zero operand skips the
// nibble steps and the result (0) is presented one cycle after accept.
module mul_seq8
  import mul_seq8_pkg::*;
#(
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  result,
  output logic              busy
);

  localparam logic IS_SIGNED = (SIGNED != 0);

  state_e               state_q;
  logic [1:0]           step_q;
  logic [OP_W-1:0]      ma_q;
  logic [OP_W-1:0]      mb_q;
  logic                 neg_q;
  logic [RES_W-1:0]     acc_q;
  logic [RES_W-1:0]     result_q;
  logic                 res_valid_q;
  logic                 req_ready_q;
  logic                 busy_q;
`ifdef MUL_SEQ8_EARLY_EXIT_EN
  logic                 zero_q;
`endif

  logic [NIB_W-1:0]     nib_a_s;
  logic [NIB_W-1:0]     nib_b_s;
  logic [2*NIB_W-1:0]   pp_s;
  logic [RES_W-1:0]     acc_d;
  logic [RES_W-1:0]     fixed_d;
  logic [OP_W-1:0]      ma_in_s;
  logic [OP_W-1:0]      mb_in_s;
  logic                 neg_in_s;
  logic                 last_step_s;

  // Operand magnitudes and result sign captured at accept.
  assign ma_in_s  = mag8(a, IS_SIGNED);
  assign mb_in_s  = mag8(b, IS_SIGNED);
  assign neg_in_s = IS_SIGNED & (a[OP_W-1] ^ b[OP_W-1]);

  // Step-driven nibble select feeding the shared 4x4 cell.
  always_comb begin
    nib_a_s = ma_q[3:0];
    nib_b_s = mb_q[3:0];
    case (step_q)
      2'd0: begin
        nib_a_s = ma_q[3:0];
        nib_b_s = mb_q[3:0];
      end
      2'd1: begin
        nib_a_s = ma_q[7:4];
        nib_b_s = mb_q[3:0];
      end
      2'd2: begin
        nib_a_s = ma_q[3:0];
        nib_b_s = mb_q[7:4];
      end
      2'd3: begin
        nib_a_s = ma_q[7:4];
        nib_b_s = mb_q[7:4];
      end
      default: begin
        nib_a_s = ma_q[3:0];
        nib_b_s = mb_q[3:0];
      end
    endcase
  end

  mul2 u_mul2 (
    .a_i (nib_a_s),
    .b_i (nib_b_s),
    .p_o (pp_s)
  );

  // Zero-extend the nibble product before shifting so the high bits survive.
  assign acc_d       = acc_q + ({8'd0, pp_s} << step_shift(step_q));
  assign fixed_d     = neg_q ? (16'd0 - acc_d) : acc_d;
  assign last_step_s = (step_q == 2'(NUM_STEPS - 1));

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= 2'd0;
      ma_q        <= 8'd0;
      mb_q        <= 8'd0;
      neg_q       <= 1'b0;
      acc_q       <= 16'd0;
      result_q    <= 16'd0;
      res_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MUL_SEQ8_EARLY_EXIT_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            ma_q        <= ma_in_s;
            mb_q        <= mb_in_s;
            neg_q       <= neg_in_s;
            acc_q       <= 16'd0;
            step_q      <= 2'd0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_MUL;
`ifdef MUL_SEQ8_EARLY_EXIT_EN
            zero_q      <= (ma_in_s == 8'd0) || (mb_in_s == 8'd0);
`endif
          end
        end
        ST_MUL: begin
`ifdef MUL_SEQ8_EARLY_EXIT_EN
          if (zero_q) begin
            // Product is known to be zero: skip the nibble steps.
            result_q    <= 16'd0;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            acc_q  <= acc_d;
            step_q <= step_q + 2'd1;
            if (last_step_s) begin
              result_q    <= fixed_d;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
`else
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (last_step_s) begin
            result_q    <= fixed_d;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
`endif
        end
        ST_DONE: begin
          // Returning to IDLE here means a new request waits one more cycle.
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
